// File: rtl/audio_dac_serializer_pkg.sv
// rtl/audio_dac_serializer_pkg.sv - shared types for the I2S DAC serializer
package audio_pkg;

  localparam int DEFAULT_DATA_WIDTH = 24;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] left;
    logic [DEFAULT_DATA_WIDTH-1:0] right;
  } stereo_sample_t;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } dac_state_t;

endpackage

// File: rtl/audio_dac_serializer_if.sv
// rtl/audio_dac_serializer_if.sv - stereo sample write handshake
interface audio_dac_serializer_if
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                  write;
  logic [DATA_WIDTH-1:0] writedata_left;
  logic [DATA_WIDTH-1:0] writedata_right;
  logic                  write_ready;

  modport master (
    output write,
    output writedata_left,
    output writedata_right,
    input  write_ready
  );

  modport slave (
    input  write,
    input  writedata_left,
    input  writedata_right,
    output write_ready
  );

endinterface

// File: rtl/audio_dac_serializer_fifo.sv
// rtl/audio_dac_serializer_fifo.sv - synchronous FIFO of stereo sample pairs
module sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  stereo_sample_t           push_data,
  input  logic                     pop,
  output stereo_sample_t           pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  stereo_sample_t   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full and empty come from the registered level, so a pop never frees room for a same-cycle push.
  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// rtl/audio_dac_serializer.sv - buffers stereo pairs and shifts them out as I2S on the codec DAC line
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  audio_dac_serializer_if.slave         wr,
  input  logic                          bclk,
  input  logic                          daclrck,
  output logic                          dacdat,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [2:0]            bclk_sync;
  logic [2:0]            lrck_sync;
  logic                  bclk_fall;
  logic                  lrck_fall;
  logic                  lrck_rise;

  dac_state_t            state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic [CNT_W-1:0]      bit_cnt;

  stereo_sample_t        push_data;
  stereo_sample_t        pop_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  word_load;

  // Bits [1:0] synchronize, bit [2] is history; detect pulses are registered so
  // a pin edge shows up three clk cycles later.
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_fall <= 1'b0;
      lrck_fall <= 1'b0;
      lrck_rise <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], bclk};
      lrck_sync <= {lrck_sync[1:0], daclrck};
      bclk_fall <= bclk_sync[2] & ~bclk_sync[1];
      lrck_fall <= lrck_sync[2] & ~lrck_sync[1];
      lrck_rise <= ~lrck_sync[2] & lrck_sync[1];
    end
  end

  assign push_data      = '{left: wr.writedata_left, right: wr.writedata_right};
  assign wr.write_ready = ~fifo_full;
  assign pop            = lrck_fall && (state != LEFT) && !fifo_empty;
  assign word_load      = (state == LEFT) ? lrck_rise : lrck_fall;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr.write),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // An LRCK edge wins over a coincident bclk_fall: the word loads and the
  // one-bit I2S delay slot is emitted instead of a shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SYNC;
      shift_reg <= '0;
      hold_reg  <= '0;
      bit_cnt   <= '0;
      dacdat    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (word_load) begin
        dacdat  <= 1'b0;
        bit_cnt <= '0;
        if (state == LEFT) begin
          shift_reg <= hold_reg;
          state     <= RIGHT;
        end else begin
          state <= LEFT;
          if (!fifo_empty) begin
            shift_reg <= pop_data.left;
            hold_reg  <= pop_data.right;
          end else begin
            shift_reg <= '0;
            hold_reg  <= '0;
            underflow <= 1'b1;
          end
        end
      end else if (bclk_fall && (state != SYNC)) begin
        if (bit_cnt < CNT_W'(DATA_WIDTH)) begin
          dacdat    <= shift_reg[DATA_WIDTH-1];
          shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
          bit_cnt   <= bit_cnt + CNT_W'(1);
        end else begin
          dacdat <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/audio_dac_serializer.md
# audio_dac_serializer

Transmit end of the codec write path. Accepts stereo sample pairs from the filter/noise datapath via the `write`/`write_ready` handshake and buffers them in a small FIFO. Shifts the samples out MSB-first on the codec DAC serial line in I2S format, timed by the codec-supplied `AUD_BCLK` and `AUD_DACLRCK`. Sits between the sample-producing logic and the `AUD_DACDAT` pin.

## Interface
- `DATA_WIDTH`, 24, bits per channel sample.
- `FIFO_DEPTH`, 4, stereo pairs buffered; power of two, ≥2.
- `clk`  in  1  system clock (`CLOCK_50`); the only clock.
- `reset`  in  1  synchronous, active-high.
- `write`  in  1  push request; accepted when `write && write_ready`.
- `writedata_left`  in  DATA_WIDTH  left sample.
- `writedata_right`  in  DATA_WIDTH  right sample.
- `write_ready`  out  1  FIFO not full; reset value 1.
- `bclk`  in  1  codec bit clock, asynchronous to `clk`.
- `daclrck`  in  1  codec DAC LR clock, asynchronous; 0 = left, 1 = right.
- `dacdat`  out  1  serial DAC data; reset value 0.
- `underflow`  out  1  one-cycle pulse: frame start found FIFO empty; reset value 0.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  occupied entries; reset value 0.

## Operation
- `bclk` and `daclrck` each pass through a 2-flop synchronizer plus one history flop. Edge detect yields `bclk_fall`, `lrck_fall`, and `lrck_rise`.
- The FSM has three states: SYNC, LEFT, and RIGHT. Reset enters SYNC.
  - SYNC: `dacdat` = 0. `lrck_rise` is ignored. On `lrck_fall`, pop and go to LEFT.
  - LEFT: on `lrck_rise`, load the shift register from the right hold register and go to RIGHT.
  - RIGHT: on `lrck_fall`, pop and go to LEFT.
- Pop at `lrck_fall`:
  - If the FIFO is non-empty, the left word goes to the shift register and the right word to the hold register.
  - If empty, both load 0 and `underflow` pulses for exactly one cycle.
- Word load (any LRCK edge) does three things: `dacdat` ← 0 (the I2S one-bit delay slot), bit counter ← 0, and shift register loaded.
- Each following `bclk_fall` while counter < DATA_WIDTH: `dacdat` ← shift MSB, shift left by one, counter+1.
- Once the counter reaches DATA_WIDTH: `dacdat` ← 0 on every `bclk_fall` until the next LRCK edge.
- If an LRCK edge and `bclk_fall` are detected in the same cycle, the LRCK edge has priority: load the word, do not shift.
- FIFO rules:
  - Push and pop in the same cycle are both performed; level is unchanged.
  - `write_ready` = level < FIFO_DEPTH, evaluated from the registered level. When full, a push is rejected even if a pop occurs that cycle.
  - Pop decision uses the registered level. A push in the same cycle as `lrck_fall` with level 0 still produces underflow; that pair goes out next frame.
  - `write` while `!write_ready` is ignored; FIFO contents are unchanged.
- Reset mid-operation:
  - All state is cleared: FIFO, shift register, hold register, and counter.
  - `dacdat` = 0 on the cycle after `reset` is sampled high.
  - No data is output until the first `lrck_fall` after reset deasserts.

## Timing
- Synchronizer latency: a pin edge is visible as a detect pulse 3 `clk` cycles later. `dacdat` updates on the cycle after the detect.
- `bclk` high and low phases must each be ≥ 4 `clk` cycles.
- Frame length is set by the codec. If the BCLK count per half-frame is < DATA_WIDTH+1, the word is truncated at the LRCK edge; this is not an error.
- `write_ready` and `fifo_level` update the cycle after an accepted push or pop.
- Latency from push into an empty FIFO to MSB on `dacdat`: next `lrck_fall` + 1 BCLK period + 4 `clk`.

## Structure
- Shared package `audio_pkg`:
  - `DATA_WIDTH` default constant.
  - `stereo_sample_t` struct {left, right}.
  - `dac_state_t` enum {SYNC, LEFT, RIGHT}.
- Sub-module `sample_fifo`: synchronous FIFO of `stereo_sample_t` with push, pop, full, empty, and level.
- Top module: synchronizers, edge detect, FSM, shift register, and counter.

## Test plan
Bench setup: `bclk` half-period 8 `clk`; `daclrck` toggles on `bclk` falling edges, every 32 BCLK.
1. Reset held 5 cycles → `dacdat`=0, `write_ready`=1, `underflow`=0, `fifo_level`=0. No activity until the first `lrck_fall`.
2. Push L=24'hA5A5A5, R=24'h3C3C3C, then let the frame run. Left half-frame: slot 0 = 0, slots 1–24 = A5A5A5 MSB first, slots 25–31 = 0. Right half-frame: 3C3C3C in the same positions. `fifo_level` 1→0 at `lrck_fall`.
3. Four pushes with no LRCK activity → `write_ready`=0 after the 4th and `fifo_level`=4. A 5th push (24'h111111) is dropped: the frames carry only the first 4 pairs.
4. Empty FIFO at `lrck_fall` → `underflow` high exactly 1 cycle; all 64 slots of that frame are 0; FSM stays in the LEFT/RIGHT cadence.
5. Reset asserted mid-left word (after bit 10) → `dacdat`=0 from the next cycle. `fifo_level`=0. A pair pushed after reset appears intact, starting at the next `lrck_fall`.
6. Push coincident with the `lrck_fall` detect, FIFO empty → `underflow` pulses. The pushed pair is output in the following frame, and `fifo_level` reads 1 in between.
